// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises a 10-bit {cmd, payload} word MSB-first and, for
// read-data frames, receives one byte after a fixed turnaround.
module spi_master_ctrl #(
   parameter int unsigned TURNAROUND = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT,
      ST_RECV,
      ST_DONE
   } state_t;

   localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

   state_t     state_q, state_d;
   logic [9:0] shreg_q, shreg_d;
   logic [3:0] cnt_q, cnt_d;
   logic       is_rd_q, is_rd_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       ss_n_q, ss_n_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      is_rd_d   = is_rd_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      ss_n_d    = ss_n_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ss_n_d = 1'b1;
            mosi_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               // mosi is registered, so bit 9 is presented straight from the inputs
               shreg_d = {cmd, data};
               cnt_d   = '0;
               is_rd_d = (cmd == 2'b11);
               state_d = ST_SHIFT;
               ss_n_d  = 1'b0;
               mosi_d  = cmd[1];
               busy_d  = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (cnt_q == 4'd9) begin
               cnt_d  = '0;
               mosi_d = 1'b0;
               if (is_rd_q) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_DONE;
                  ss_n_d  = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               shreg_d = {shreg_q[8:0], 1'b0};
               mosi_d  = shreg_q[8];
               cnt_d   = cnt_q + 4'd1;
            end
         end

         ST_WAIT: begin
            mosi_d = 1'b0;
            if (cnt_q == TA_LAST) begin
               cnt_d   = '0;
               state_d = ST_RECV;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_RECV: begin
            mosi_d = 1'b0;
            rx_d   = {rx_q[6:0], miso};
            if (cnt_q == 4'd7) begin
               cnt_d     = '0;
               state_d   = ST_DONE;
               ss_n_d    = 1'b1;
               done_d    = 1'b1;
               rd_data_d = {rx_q[6:0], miso};
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ss_n_d  = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         is_rd_q   <= 1'b0;
         rx_q      <= '0;
         rd_data_q <= '0;
         ss_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         is_rd_q   <= is_rd_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         ss_n_q    <= ss_n_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
   assign ss_n    = ss_n_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: frames are queued when started and
// checked by a negedge monitor when the done pulse appears.
module tb_spi_master_ctrl;

   localparam int unsigned T = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic [7:0] rd_data;
   logic       ss_n;
   logic       mosi;
   logic       miso;

   int n_err = 0;
   int n_chk = 0;
   int frames_seen = 0;

   typedef struct {
      logic [9:0] bits;
      int         low;
      logic [7:0] rd;
      int         gap;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] rd_model;

   spi_master_ctrl #(.TURNAROUND(T)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .cmd     (cmd),
      .data    (data),
      .busy    (busy),
      .done    (done),
      .rd_data (rd_data),
      .ss_n    (ss_n),
      .mosi    (mosi),
      .miso    (miso)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic expect_frame(input logic [1:0] c, input logic [7:0] d,
                               input logic [7:0] rx, input int gap);
      exp_t e;
      e.bits = {c, d};
      e.low  = (c == 2'b11) ? int'(10 + T + 8) : 10;
      if (c == 2'b11) rd_model = rx;
      e.rd   = rd_model;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // monitor: capture the first 10 low-ss_n bits, count frame length and gaps
   logic [9:0] cap;
   int         nbits = 0, low_cnt = 0, mosi_extra = 0, high_run = 0, gap_cap = 0;
   logic       chk_idle = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         nbits = 0; low_cnt = 0; mosi_extra = 0; high_run = 0; gap_cap = 0;
         chk_idle = 1'b0;
      end else begin
         if (chk_idle) begin
            check_eq("busy_after_done", 32'(busy), 32'(0));
            check_eq("done_width", 32'(done), 32'(0));
            chk_idle = 1'b0;
         end
         if (!ss_n) begin
            if (nbits == 0) gap_cap = high_run;
            high_run = 0;
            if (nbits < 10) begin
               cap = {cap[8:0], mosi};
               nbits++;
            end else if (mosi !== 1'b0) begin
               mosi_extra++;
            end
            low_cnt++;
         end else begin
            high_run++;
         end
         if (done) begin
            frames_seen++;
            check_eq("frame_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check_eq("mosi_bits", 32'(cap), 32'(mon_e.bits));
               check_eq("ss_n_low_cycles", 32'(low_cnt), 32'(mon_e.low));
               check_eq("mosi_zero_after_bits", 32'(mosi_extra), 32'(0));
               check_eq("rd_data", 32'(rd_data), 32'(mon_e.rd));
               check_eq("busy_in_done", 32'(busy), 32'(1));
               check_eq("ss_n_in_done", 32'(ss_n), 32'(1));
               if (mon_e.gap > 0) check_eq("ss_n_gap", 32'(gap_cap), 32'(mon_e.gap));
            end
            nbits = 0; low_cnt = 0; mosi_extra = 0;
            chk_idle = 1'b1;
         end
      end
   end

   task automatic wait_done(input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < maxc);
      check_eq("done_seen", 32'(done), 32'(1));
   endtask

   // miso bit 7..0 must be stable at E(11+T)..E(18+T)
   task automatic drive_rx(input logic [7:0] rx);
      logic [7:0] sh;
      sh = rx;
      for (int k = 1; k <= int'(17 + T); k++) begin
         @(posedge clk); #1;
         if (k >= int'(10 + T)) begin
            miso = sh[7];
            sh   = {sh[6:0], 1'b0};
         end
      end
   endtask

   task automatic start_frame(input logic [1:0] c, input logic [7:0] d,
                              input logic [7:0] rx, input int gap);
      @(posedge clk); #1;
      start = 1'b1; cmd = c; data = d;
      expect_frame(c, d, rx, gap);
      @(posedge clk); #1;
      start = 1'b0; cmd = ~c; data = ~d;
      if (c == 2'b11) drive_rx(rx);
      wait_done(40);
      miso = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b1; cmd = 2'b01; data = 8'hFF; miso = 1'b0; rd_model = 8'h00;

      // reset with start held high
      repeat (2) @(posedge clk);
      #1; rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_eq("rst_ss_n", 32'(ss_n), 32'(1));
      check_eq("rst_mosi", 32'(mosi), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_done", 32'(done), 32'(0));
      check_eq("rst_rd_data", 32'(rd_data), 32'(0));
      @(negedge clk);
      check_eq("rst_no_frame", 32'(busy), 32'(0));

      // write-address
      start_frame(2'b00, 8'h01, 8'h00, 0);

      // write-data then read-address with start held high
      @(posedge clk); #1;
      start = 1'b1; cmd = 2'b01; data = 8'hAA;
      expect_frame(2'b01, 8'hAA, 8'h00, 0);
      expect_frame(2'b10, 8'h01, 8'h00, 2);
      @(posedge clk); #1;
      cmd = 2'b10; data = 8'h01;
      repeat (12) @(posedge clk);
      #1; start = 1'b0;
      wait_done(20);

      // read-data
      start_frame(2'b11, 8'h00, 8'hA5, 0);

      // busy/stability: input changes and start pulses mid-frame are ignored
      @(posedge clk); #1;
      start = 1'b1; cmd = 2'b00; data = 8'h3C;
      expect_frame(2'b00, 8'h3C, 8'h00, 0);
      @(posedge clk); #1;
      start = 1'b0; cmd = 2'b11; data = 8'hFF;
      repeat (4) @(posedge clk);
      #1; start = 1'b1; cmd = 2'b01; data = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(20);
      start = 1'b1; cmd = 2'b10; data = 8'h77;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("no_extra_frame_busy", 32'(busy), 32'(0));
      check_eq("no_extra_frame_ss_n", 32'(ss_n), 32'(1));

      // reset at E15 of a read-data frame
      @(posedge clk); #1;
      start = 1'b1; cmd = 2'b11; data = 8'h00;
      expect_frame(2'b11, 8'h00, 8'h3C, 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (k >= int'(10 + T)) miso = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; miso = 1'b0;
      sb.delete();
      rd_model = 8'h00;
      @(negedge clk);
      check_eq("abort_ss_n", 32'(ss_n), 32'(1));
      check_eq("abort_done", 32'(done), 32'(0));
      check_eq("abort_busy", 32'(busy), 32'(0));
      check_eq("abort_mosi", 32'(mosi), 32'(0));
      check_eq("abort_rd_data", 32'(rd_data), 32'(0));
      start_frame(2'b01, 8'h81, 8'h00, 0);

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 32'(sb.size()), 32'(0));
      check_eq("frames_seen", 32'(frames_seen), 32'(6));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
